fetch_pc_unit: RTL and testbench

Fetch-stage PC owner and instruction-bus requester. It consumes the `branch_ctl` redirect (flush plus `pcSelect`) that the memory-stage branch checker produces, and computes the next PC. It issues one instruction fetch at a time on the ibus and presents the fetched instruction to decode through a valid/ready handshake. It also drops any fetch made stale by a redirect.

---
 rtl/fetch_pc_unit_pkg.sv | 34 +++
 rtl/fetch_pc_unit_target.sv | 23 ++
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch stage: bus structs, branch redirect bundle,
// PC select encoding and the fetch FSM state.
package fetch_pc_unit_pkg;

    localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        PC_From_add4    = 2'd0,
        PC_From_add_imm = 2'd1,
        PC_From_jalr    = 2'd2
    } pc_select_t;

    typedef struct packed {
        logic       flush;
        pc_select_t pcSelect;
    } branch_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_target.sv
// Redirect target mux for the three PC select cases; all sums wrap modulo
// 2^64 and bit 1 is passed through untouched (no alignment trap).
module pc_target_gen
    import fetch_pc_unit_pkg::*;
(
    input  pc_select_t  sel,
    input  logic [63:0] branch_pc,
    input  logic [63:0] rd1,
    input  logic [63:0] imm_64,
    output logic [63:0] target
);

    always_comb begin
        target = branch_pc + 64'd4;
        unique case (sel)
            PC_From_add4:    target = branch_pc + 64'd4;
            PC_From_add_imm: target = branch_pc + imm_64;
            PC_From_jalr:    target = (rd1 + imm_64) & ~64'h1;
            default:         target = branch_pc + 64'd4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: one outstanding ibus fetch at a time, valid/ready
// hand-off to decode, and dropping of fetches made stale by a redirect.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  branch_data_t branch_ctl,
    input  logic [63:0]  branch_pc,
    input  logic [63:0]  rd1,
    input  logic [63:0]  imm_64,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_pc,
    output logic [31:0]  out_instr
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [63:0]  pc;
    logic [31:0]  instr_q;
    logic [63:0]  target_q;
    logic [63:0]  target;
    logic         flush;

    assign flush = branch_ctl.flush;

    pc_target_gen u_target (
        .sel       (branch_ctl.pcSelect),
        .branch_pc (branch_pc),
        .rd1       (rd1),
        .imm_64    (imm_64),
        .target    (target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            REQ: begin
                if (iresp.data_ok) begin
                    state_next = flush ? REQ : HOLD;
                end else if (flush) begin
                    state_next = DISCARD;
                end
            end
            HOLD: begin
                if (flush || out_ready) begin
                    state_next = REQ;
                end
            end
            DISCARD: begin
                if (iresp.data_ok) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // pc stays on the in-flight address until data_ok; redirects that arrive
    // while a request is outstanding are parked in target_q instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= PCINIT;
            instr_q  <= '0;
            target_q <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (iresp.data_ok && flush) begin
                        pc <= target;
                    end else if (iresp.data_ok) begin
                        instr_q <= iresp.data;
                    end else if (flush) begin
                        target_q <= target;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc <= target;
                    end else if (out_ready) begin
                        pc <= pc + 64'd4;
                    end
                end
                DISCARD: begin
                    if (iresp.data_ok) begin
                        pc <= flush ? target : target_q;
                    end else if (flush) begin
                        target_q <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ireq.valid = (state != HOLD);
        ireq.addr  = pc;
        out_valid  = (state == HOLD);
        out_pc     = pc;
        out_instr  = instr_q;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam logic [63:0] INIT = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    branch_data_t branch_ctl;
    logic [63:0]  branch_pc;
    logic [63:0]  rd1;
    logic [63:0]  imm_64;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_pc;
    logic [31:0]  out_instr;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.PCINIT(INIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .branch_ctl (branch_ctl),
        .branch_pc  (branch_pc),
        .rd1        (rd1),
        .imm_64     (imm_64),
        .ireq       (ireq),
        .iresp      (iresp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_target(input pc_select_t s, input logic [63:0] bpc,
                                               input logic [63:0] r1, input logic [63:0] imm);
        logic [63:0] t;
        if (s == PC_From_add_imm) t = bpc + imm;
        else if (s == PC_From_jalr) begin
            t = r1 + imm;
            t[0] = 1'b0;
        end else t = bpc + 64'd4;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_ctl = '0;
        branch_pc  = '0;
        rd1        = '0;
        imm_64     = '0;
        iresp      = '0;
        out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_flush(input pc_select_t s, input logic [63:0] bpc,
                             input logic [63:0] r1, input logic [63:0] imm);
        branch_ctl.flush    = 1'b1;
        branch_ctl.pcSelect = s;
        branch_pc           = bpc;
        rd1                 = r1;
        imm_64              = imm;
    endtask

    // Zero-wait fetch of n instructions, each accepted in the cycle it is shown.
    task automatic run_fetches(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            iresp.data_ok = 1'b1;
            iresp.data    = 32'h1000_0000 + 32'(i);
            tick();
            iresp = '0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (ireq.valid !== 1'b1) begin errors++; $display("FAIL reset_ireq_valid: got %b expected 1", ireq.valid); end
        checks++; if (ireq.addr !== INIT) begin errors++; $display("FAIL reset_ireq_addr: got %h expected %h", ireq.addr, INIT); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc !== INIT) begin errors++; $display("FAIL reset_out_pc: got %h expected %h", out_pc, INIT); end
    endtask

    task automatic test_stream();
        logic [63:0] a;
        logic [31:0] d;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = INIT + 64'(4 * i);
            d = 32'hA5A5_0000 ^ 32'(i * 7919);
            checks++; if (ireq.valid !== 1'b1 || ireq.addr !== a) begin errors++; $display("FAIL stream_req[%0d]: got valid=%b addr=%h expected valid=1 addr=%h", i, ireq.valid, ireq.addr, a); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid[%0d]: got %b expected 0", i, out_valid); end
            iresp.data_ok = 1'b1;
            iresp.data    = d;
            tick();
            iresp = '0;
            checks++; if (out_valid !== 1'b1 || ireq.valid !== 1'b0) begin errors++; $display("FAIL stream_present[%0d]: got out_valid=%b ireq.valid=%b expected 1/0", i, out_valid, ireq.valid); end
            checks++; if (out_instr !== d || out_pc !== a) begin errors++; $display("FAIL stream_data[%0d]: got %h@%h expected %h@%h", i, out_instr, out_pc, d, a); end
            tick();
        end
    endtask

    task automatic test_flush_hold();
        do_reset();
        run_fetches(4);
        out_ready     = 1'b0;
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hBAD0_0010;
        tick();
        iresp = '0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0010) begin errors++; $display("FAIL hold_setup: got valid=%b pc=%h expected 1 8000_0010", out_valid, out_pc); end
        out_ready = 1'b1;
        set_flush(PC_From_add_imm, 64'h8000_0008, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        branch_ctl = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_flush_valid: got %b expected 0", out_valid); end
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin errors++; $display("FAIL hold_flush_addr: got valid=%b addr=%h expected 1 8000_0000", ireq.valid, ireq.addr); end
        iresp.data_ok = 1'b1;
        iresp.data    = 32'h600D_0000;
        tick();
        iresp = '0;
        checks++; if (out_instr !== 32'h600D_0000 || out_pc !== 64'h8000_0000) begin errors++; $display("FAIL hold_flush_next: got %h@%h expected 600d0000@80000000", out_instr, out_pc); end
    endtask

    task automatic test_discard_jalr();
        do_reset();
        tick();
        set_flush(PC_From_jalr, 64'h0, 64'h8000_1001, 64'd2);
        tick();
        branch_ctl = '0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ireq.valid !== 1'b1 || ireq.addr !== INIT || out_valid !== 1'b0) begin errors++; $display("FAIL discard_hold_addr[%0d]: got valid=%b addr=%h ov=%b expected 1 %h 0", i, ireq.valid, ireq.addr, out_valid, INIT); end
            if (i == 1) begin
                iresp.data_ok = 1'b1;
                iresp.data    = 32'hDEAD_BEEF;
            end
            tick();
        end
        iresp = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discard_no_valid: got %b expected 0", out_valid); end
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_1002) begin errors++; $display("FAIL discard_target: got valid=%b addr=%h expected 1 80001002", ireq.valid, ireq.addr); end
        iresp.data_ok = 1'b1;
        iresp.data    = 32'h1234_5678;
        tick();
        iresp = '0;
        checks++; if (out_instr !== 32'h1234_5678 || out_pc !== 64'h8000_1002) begin errors++; $display("FAIL discard_next: got %h@%h expected 12345678@80001002", out_instr, out_pc); end
    endtask

    task automatic test_double_flush();
        do_reset();
        set_flush(PC_From_add_imm, 64'h8000_0000, 64'h0, 64'h100);
        tick();
        set_flush(PC_From_add_imm, 64'h8000_0000, 64'h0, 64'h200);
        tick();
        branch_ctl = '0;
        checks++; if (ireq.addr !== INIT) begin errors++; $display("FAIL dflush_hold_addr: got %h expected %h", ireq.addr, INIT); end
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hDEAD_0001;
        tick();
        iresp = '0;
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0200 || out_valid !== 1'b0) begin errors++; $display("FAIL dflush_target: got valid=%b addr=%h ov=%b expected 1 80000200 0", ireq.valid, ireq.addr, out_valid); end
    endtask

    task automatic test_flush_with_ok();
        do_reset();
        set_flush(PC_From_add4, 64'h8000_0040, 64'h0, 64'h0);
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hDEAD_0002;
        tick();
        clear_inputs();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL okflush_valid: got %b expected 0", out_valid); end
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0044) begin errors++; $display("FAIL okflush_addr: got valid=%b addr=%h expected 1 80000044", ireq.valid, ireq.addr); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        run_fetches(2);
        out_ready     = 1'b0;
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hCAFE_0000;
        tick();
        iresp = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rhold_setup: got %b expected 1", out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || ireq.valid !== 1'b1 || ireq.addr !== INIT) begin errors++; $display("FAIL rhold_reset: got ov=%b valid=%b addr=%h expected 0 1 %h", out_valid, ireq.valid, ireq.addr, INIT); end
    endtask

    task automatic test_random();
        logic [63:0] m_pc, m_tq, tgt, prev_addr;
        logic [31:0] m_instr;
        bit          m_hold, m_stale, ok, fl, prev_wait;
        int          lat;
        do_reset();
        m_pc = INIT; m_tq = '0; m_instr = '0; m_hold = 0; m_stale = 0;
        lat = -1; prev_wait = 0; prev_addr = '0;
        for (int c = 0; c < 800; c++) begin
            checks++; if (ireq.valid !== !m_hold || out_valid !== m_hold) begin errors++; $display("FAIL rand_valid[%0d]: got ireq=%b out=%b expected %b %b", c, ireq.valid, out_valid, !m_hold, m_hold); end
            if (!m_hold) begin
                checks++; if (ireq.addr !== m_pc) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", c, ireq.addr, m_pc); end
            end else begin
                checks++; if (out_pc !== m_pc || out_instr !== m_instr) begin errors++; $display("FAIL rand_out[%0d]: got %h@%h expected %h@%h", c, out_instr, out_pc, m_instr, m_pc); end
            end
            if (prev_wait) begin
                checks++; if (ireq.addr !== prev_addr) begin errors++; $display("FAIL rand_addr_stable[%0d]: got %h expected %h", c, ireq.addr, prev_addr); end
            end
            ok = 0;
            if (!m_hold) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin ok = 1; lat = -1; end
                else lat--;
            end
            fl = ($urandom_range(0, 3) == 0);
            iresp.data_ok       = ok;
            iresp.data          = $urandom;
            branch_ctl.flush    = fl;
            branch_ctl.pcSelect = pc_select_t'($urandom_range(0, 2));
            branch_pc           = {$urandom, $urandom};
            rd1                 = {$urandom, $urandom};
            imm_64              = {{32{1'b0}}, $urandom} - 64'h8000_0000;
            out_ready           = $urandom_range(0, 1) == 1;
            tgt = ref_target(branch_ctl.pcSelect, branch_pc, rd1, imm_64);
            prev_wait = !m_hold && !ok;
            prev_addr = m_pc;
            // Reference: a held instruction leaves on accept or redirect; a
            // request completes on data_ok and is dropped if any redirect
            // arrived during or at the end of its flight.
            if (m_hold) begin
                if (fl) begin m_pc = tgt; m_hold = 0; end
                else if (out_ready) begin m_pc = m_pc + 64'd4; m_hold = 0; end
            end else if (ok) begin
                if (fl) m_pc = tgt;
                else if (m_stale) m_pc = m_tq;
                else begin m_instr = iresp.data; m_hold = 1; end
                m_stale = 0;
            end else if (fl) begin
                m_tq = tgt;
                m_stale = 1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_stream();
        test_flush_hold();
        test_discard_jalr();
        test_double_flush();
        test_flush_with_ok();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
